// File: rtl/mux_rr_stream.sv
`default_nettype none
// ============================================================================
// mux_rr_stream : N-channel valid/ready stream mux, fixed-select or round-robin
// Revision      : 1.0
// ============================================================================
module mux_rr_stream #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_next;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic             load_en;
    logic             transfer;

    assign load_en = !out_valid || out_ready;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            // Loop compare keeps out-of-range sel values from ever granting
            for (int i = 0; i < N_CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Scan downward so the channel closest to rr_ptr is assigned last
            for (int k = N_CH - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                if (in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = rst_n && grant_vld && load_en && (grant_idx == SEL_W'(i));
        end
    end

    assign transfer = |(in_valid & in_ready);
    assign rr_next  = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_ch    <= grant_idx;
                if (mode) begin
                    rr_ptr <= rr_next;
                end
            end else if (load_en) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_stream.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_stream : scoreboard bench for mux_rr_stream (4-ch and 3-ch builds)
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mux_rr_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  r3;
    logic        ov3;
    logic        ord3;
    logic [7:0]  od3;
    logic [1:0]  oc3;

    mux_rr_stream #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch)
    );

    mux_rr_stream #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(v3), .in_data(d3), .in_ready(r3),
        .out_valid(ov3), .out_ready(ord3),
        .out_data(od3), .out_ch(oc3)
    );

    int          vectors = 0;
    int          errors  = 0;
    logic        m_valid;
    logic [1:0]  m_rr;
    logic [9:0]  sbq[$];
    logic [3:0]  exp_rdy;
    logic [3:0]  got_rdy;

    // Reference model of the 4-channel DUT; pushes each predicted load.
    task automatic apply();
        logic le;
        logic gv;
        int   g;
        #1;
        got_rdy = in_ready;
        exp_rdy = 4'b0000;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_rr    = 2'd0;
            sbq.delete();
        end else begin
            le = !m_valid || out_ready;
            gv = 1'b0;
            g  = 0;
            if (!mode) begin
                if (in_valid[sel]) begin
                    gv = 1'b1;
                    g  = int'(sel);
                end
            end else begin
                for (int k = 0; k < 4 && !gv; k++) begin
                    int c;
                    c = (int'(m_rr) + k) % 4;
                    if (in_valid[c]) begin
                        gv = 1'b1;
                        g  = c;
                    end
                end
            end
            if (m_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
            if (gv && le) begin
                exp_rdy[g] = 1'b1;
                sbq.push_back({2'(g), in_data[g*8 +: 8]});
                m_valid = 1'b1;
                if (mode) m_rr = 2'(g + 1);
            end else if (le) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
        apply();
        apply();
        vectors++;
        if (got_rdy !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", got_rdy);
        end
        vectors++;
        if ({out_valid, out_data, out_ch} !== 11'd0) begin
            errors++; $display("FAIL reset_out: got v=%b d=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch);
        end
        vectors++;
        if (ov3 !== 1'b0) begin
            errors++; $display("FAIL reset_out3: got v=%b want 0", ov3);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_select();
        logic [7:0] tbl [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
        mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h43, 8'h32, 8'h21, 8'h10};
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            apply();
            vectors++;
            if (got_rdy !== exp_rdy || got_rdy !== (4'b0001 << s)) begin
                errors++; $display("FAIL fixed_ready[%0d]: got %b want %b", s, got_rdy, exp_rdy);
            end
            vectors++;
            if (out_valid !== 1'b1 || out_data !== tbl[s] || out_ch !== 2'(s)) begin
                errors++; $display("FAIL fixed_out[%0d]: got v=%b d=%h ch=%0d want 1/%h/%0d", s, out_valid, out_data, out_ch, tbl[s], s);
            end
        end
    endtask

    task automatic test_rr_fairness();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply();
            vectors++;
            if (!$onehot(got_rdy) || got_rdy !== exp_rdy) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, got_rdy, exp_rdy);
            end
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || {out_ch, out_data} !== sbq[0]) begin
                errors++; $display("FAIL rr_order[%0d]: got ch=%0d d=%h want ch=%0d", i, out_ch, out_data, i % 4);
            end
        end
    endtask

    task automatic test_rr_skip();
        logic [1:0] exp_ch [3] = '{2'd3, 2'd0, 2'd3};
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0001;
        apply();
        in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            apply();
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch[i] || {out_ch, out_data} !== sbq[0]) begin
                errors++; $display("FAIL rr_skip[%0d]: got ch=%0d want %0d", i, out_ch, exp_ch[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h43, 8'h32, 8'h21, 8'h10};
        apply();
        out_ready = 1'b0; sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            apply();
            vectors++;
            if (got_rdy !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h21 || out_ch !== 2'd1) begin
                errors++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h ch=%0d want 0000/1/21/1", i, got_rdy, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        apply();
        vectors++;
        if (got_rdy !== 4'b0100 || out_valid !== 1'b1 || out_data !== 8'h32 || out_ch !== 2'd2) begin
            errors++; $display("FAIL bp_release: got rdy=%b d=%h ch=%0d want 0100/32/2", got_rdy, out_data, out_ch);
        end
    endtask

    task automatic test_invalid_select();
        mode3 = 1'b0; sel3 = 2'd0; v3 = 3'b111; ord3 = 1'b0;
        d3 = {8'h32, 8'h21, 8'h10};
        apply();
        vectors++;
        if (ov3 !== 1'b1 || od3 !== 8'h10 || oc3 !== 2'd0) begin
            errors++; $display("FAIL inv_load: got v=%b d=%h want 1/10", ov3, od3);
        end
        sel3 = 2'd3; ord3 = 1'b1;
        #1;
        vectors++;
        if (r3 !== 3'b000) begin
            errors++; $display("FAIL inv_ready: got %b want 000", r3);
        end
        apply();
        vectors++;
        if (ov3 !== 1'b0) begin
            errors++; $display("FAIL inv_drain: got v=%b want 0", ov3);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
        apply();
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got v=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        apply();
        rst_n = 1'b1;
        vectors++;
        if ({out_valid, out_data, out_ch} !== 11'd0) begin
            errors++; $display("FAIL mid_reset: got v=%b d=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch);
        end
        out_ready = 1'b1;
        apply();
        vectors++;
        if (got_rdy !== 4'b0001 || out_ch !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_resume: got rdy=%b ch=%0d want 0001/0", got_rdy, out_ch);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            apply();
            vectors++;
            if (got_rdy !== exp_rdy) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, got_rdy, exp_rdy);
            end
            vectors++;
            if (out_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_valid);
            end
            if (m_valid) begin
                vectors++;
                if ({out_ch, out_data} !== sbq[0]) begin
                    errors++; $display("FAIL rand_data[%0d]: got ch=%0d d=%h want ch=%0d d=%h", i, out_ch, out_data, sbq[0][9:8], sbq[0][7:0]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'h0; in_data = '0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd0; v3 = 3'b000; d3 = '0; ord3 = 1'b0;
        m_valid = 1'b0; m_rr = 2'd0;
        #2;
        test_reset();
        test_fixed_select();
        test_rr_fairness();
        test_rr_skip();
        test_backpressure();
        test_invalid_select();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100us");
        $fatal(1);
    end

endmodule
`default_nettype wire
